// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: arbiter state encoding and the helper that sizes producer ids
package fifo_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshake, fifo write port and arbiter status
//   master: producers + fifo (drive req_valid/req_last/req_data/fifo_full)
//   slave : arbiter (drives req_ready/fifo_wr/fifo_w_data/grant_id/locked/burst_err)
interface fifo_wr_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_WIDTH = 8);
  import fifo_arb_pkg::*;
  localparam int IW = id_width(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic                          fifo_full;
  logic [IW-1:0]                 grant_id;
  logic                          locked;
  logic                          burst_err;
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_w_data, grant_id, locked, burst_err
  );
  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_w_data, grant_id, locked, burst_err
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// rr_priority_picker: first valid request at or after rr_ptr_i, wrapping
//   req_i: request vector, rr_ptr_i: search start
//   grant_o: selected index (rr_ptr_i when none), any_valid_o: some request set
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [IW-1:0]      grant_o,
  output logic               any_valid_o
);
  function automatic int wrap(input int x);
    return (x >= NUM_REQ) ? x - NUM_REQ : x;
  endfunction
  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    grant_o = rr_ptr_i;
    any_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[wrap(int'(rr_ptr_i) + k)]) begin
        grant_o = IW'(wrap(int'(rr_ptr_i) + k));
        any_valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port, with packet lock
//   clk, reset (async, active-low)
//   bus (slave): producer valid/last/data/ready, fifo wr/w_data/full, grant_id/locked/burst_err
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input logic               clk,
  input logic               reset,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IW = id_width(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, grant_q, grant_d;
  logic [IW-1:0] pick, g;
  logic [BW-1:0] beat_q, beat_d;
  logic          err_q, err_d;
  logic          any_valid, sel, xfer, last;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i       (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (pick),
    .any_valid_o (any_valid)
  );

  // While locked the owner keeps the port even if it idles; reset and full mask every ready.
  assign g               = (state_q == LOCKED) ? lock_id_q : pick;
  assign sel             = reset && !bus.fifo_full && (state_q == LOCKED || any_valid);
  assign bus.req_ready   = sel ? (NUM_REQ'(1) << g) : '0;
  assign xfer            = sel && bus.req_valid[g];
  assign last            = bus.req_last[g];
  assign bus.fifo_wr     = xfer;
  assign bus.fifo_w_data = bus.req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id    = grant_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.burst_err   = err_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    err_d     = err_q;
    if (xfer && state_q == IDLE) begin
      grant_d = g;
      if (last) rr_ptr_d = nxt(g);
      else begin
        state_d   = LOCKED;
        lock_id_d = g;
        beat_d    = BW'(1);
      end
    end else if (xfer) begin
      // A non-last beat at the limit forces release and flags the overrun.
      if (last || beat_q == BW'(MAX_BURST - 1)) begin
        state_d  = IDLE;
        rr_ptr_d = nxt(lock_id_q);
        beat_d   = '0;
        err_d    = err_q | !last;
      end else beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      grant_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors with hand-computed expectations
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    #1;
  endtask

  task automatic port(input string tag, input logic wr, input logic [7:0] data, input logic [3:0] rdy);
    check({tag, "_wr"}, 32'(bus.fifo_wr), 32'(wr));
    check({tag, "_rdy"}, 32'(bus.req_ready), 32'(rdy));
    if (wr) check({tag, "_data"}, 32'(bus.fifo_w_data), 32'(data));
  endtask

  initial begin
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    set(4'hF, 4'hF, 32'h40302010);
    #2;
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_grant", 32'(bus.grant_id), 0);
    check("rst_err", 32'(bus.burst_err), 0);
    port("rst", 1'b0, 8'h00, 4'b0000);
    tick;
    port("rst_hold", 1'b0, 8'h00, 4'b0000);
    reset = 1'b1;
    #1;
    // single beats rotate 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      port("rr", 1'b1, 8'(8'h10 * (i % 4 + 1)), 4'(1 << (i % 4)));
      tick;
      check("rr_grant", 32'(bus.grant_id), 32'(i % 4));
    end
    // producer 2 locks for A0..A2 while producer 0 waits
    set(4'b0101, 4'b0001, 32'h33A00055);
    port("lk0", 1'b1, 8'hA0, 4'b0100);
    tick;
    check("lk0_locked", 32'(bus.locked), 1);
    check("lk0_grant", 32'(bus.grant_id), 2);
    set(4'b0101, 4'b0001, 32'h33A10055);
    port("lk1", 1'b1, 8'hA1, 4'b0100);
    tick;
    check("lk1_locked", 32'(bus.locked), 1);
    set(4'b0101, 4'b0101, 32'h33A20055);
    port("lk2", 1'b1, 8'hA2, 4'b0100);
    tick;
    check("lk2_locked", 32'(bus.locked), 0);
    check("lk2_grant", 32'(bus.grant_id), 2);
    set(4'b1001, 4'b1001, 32'h33000055);
    port("ptr3", 1'b1, 8'h33, 4'b1000);
    tick;
    check("ptr3_grant", 32'(bus.grant_id), 3);
    set(4'b0001, 4'b0001, 32'h00000055);
    port("p0", 1'b1, 8'h55, 4'b0001);
    tick;
    check("p0_grant", 32'(bus.grant_id), 0);
    // backpressure mid-packet on producer 1
    set(4'b0011, 4'b0000, 32'h0000B055);
    port("bp0", 1'b1, 8'hB0, 4'b0010);
    tick;
    check("bp0_locked", 32'(bus.locked), 1);
    check("bp0_grant", 32'(bus.grant_id), 1);
    set(4'b0001, 4'b0000, 32'h0000B055);
    port("bp_idle", 1'b0, 8'h00, 4'b0010);
    tick;
    bus.fifo_full = 1'b1;
    set(4'b0011, 4'b0000, 32'h0000B155);
    for (int i = 0; i < 3; i++) begin
      port("bp_full", 1'b0, 8'h00, 4'b0000);
      tick;
      check("bp_full_locked", 32'(bus.locked), 1);
    end
    bus.fifo_full = 1'b0;
    #1;
    port("bp1", 1'b1, 8'hB1, 4'b0010);
    tick;
    set(4'b0011, 4'b0010, 32'h0000B255);
    port("bp2", 1'b1, 8'hB2, 4'b0010);
    tick;
    check("bp2_locked", 32'(bus.locked), 0);
    // producer 3 overruns the 4-beat limit
    for (int j = 0; j < 4; j++) begin
      set(4'b1001, 4'b0000, {8'(8'hC0 + j), 16'h0000, 8'h55});
      port("bl", 1'b1, 8'(8'hC0 + j), 4'b1000);
      tick;
      check("bl_locked", 32'(bus.locked), 32'(j < 3));
      check("bl_err", 32'(bus.burst_err), 32'(j == 3));
    end
    check("bl_grant", 32'(bus.grant_id), 3);
    set(4'b1001, 4'b0001, 32'hC4000055);
    port("bl_next", 1'b1, 8'h55, 4'b0001);
    tick;
    check("bl_next_grant", 32'(bus.grant_id), 0);
    check("bl_next_locked", 32'(bus.locked), 0);
    // sparse requests and pointer wrap
    set(4'b1000, 4'b1000, 32'hD3000000);
    port("wr3", 1'b1, 8'hD3, 4'b1000);
    tick;
    check("wr3_grant", 32'(bus.grant_id), 3);
    set(4'b0001, 4'b0001, 32'h000000D0);
    port("wr0", 1'b1, 8'hD0, 4'b0001);
    tick;
    check("wr0_grant", 32'(bus.grant_id), 0);
    check("err_sticky", 32'(bus.burst_err), 1);
    // asynchronous reset while locked on producer 2
    set(4'b0100, 4'b0000, 32'h00E00000);
    port("ar", 1'b1, 8'hE0, 4'b0100);
    tick;
    check("ar_locked", 32'(bus.locked), 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_rst_locked", 32'(bus.locked), 0);
    check("ar_rst_grant", 32'(bus.grant_id), 0);
    check("ar_rst_err", 32'(bus.burst_err), 0);
    port("ar_rst", 1'b0, 8'h00, 4'b0000);
    #1;
    reset = 1'b1;
    set(4'b0101, 4'b0101, 32'h00E100E2);
    port("ar_after", 1'b1, 8'hE2, 4'b0001);
    tick;
    check("ar_after_grant", 32'(bus.grant_id), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo write port (wr / w_data / full) between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- A producer may lock the port for a multi-beat packet, delimited by req_last, so packets are never interleaved in the fifo.
- Sits directly in front of the fifo write side; fifo_wr, fifo_w_data and fifo_full connect to the fifo's wr, w_data and full.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 8, fifo word width; must match the fifo.
- MAX_BURST, 16, maximum beats one locked packet may hold the port before forced release.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-producer data valid.
- req_last  in  NUM_REQ  per-producer last beat of packet; sampled only with req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed producer data; producer i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-producer accept; at most one bit high.
- fifo_wr  out  1  write strobe to fifo.
- fifo_w_data  out  DATA_WIDTH  write data to fifo.
- fifo_full  in  1  fifo full flag.
- grant_id  out  $clog2(NUM_REQ)  current or last granted producer.
- locked  out  1  a packet is in progress.
- burst_err  out  1  sticky; a packet exceeded MAX_BURST.

Behaviour:
- Reset, asynchronous with reset=0:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - grant_id=0, locked=0, burst_err=0.
  - fifo_wr=0 and req_ready=0 for as long as reset=0.
- Datapath is combinational, with zero-cycle latency from req to fifo:
  - fifo_wr = req_valid[g] & req_ready[g].
  - fifo_w_data = req_data slice g.
  - g is the selected producer.
- Transfer occurs when req_valid[g] & req_ready[g]. req_ready[g] = ~fifo_full & (g selected). All other req_ready bits are 0.
- IDLE state:
  - g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - No valid requester: fifo_wr=0, no state change.
  - Transfer with req_last=1: remain IDLE; rr_ptr <= g+1 mod NUM_REQ; grant_id <= g.
  - Transfer with req_last=0: go to LOCKED; lock_id <= g; grant_id <= g; beat_cnt <= 1.
- LOCKED state:
  - g = lock_id unconditionally. Other producers' ready=0 even when the locked producer is idle (req_valid low).
  - locked=1 (registered; equals state==LOCKED).
  - Transfer with req_last=1: go to IDLE; rr_ptr <= lock_id+1 mod NUM_REQ; beat_cnt <= 0.
  - Transfer with req_last=0 and beat_cnt==MAX_BURST-1: forced release to IDLE; rr_ptr <= lock_id+1; burst_err <= 1.
  - Otherwise beat_cnt++ on each transfer.
- fifo_full=1: every req_ready=0, fifo_wr=0. State, rr_ptr and beat_cnt are frozen; the lock is held.
- rr_ptr wrap: NUM_REQ-1 -> 0 (explicit compare; NUM_REQ need not be a power of two).
- The fifo's own ~full gating is redundant but harmless; the arbiter never asserts fifo_wr while fifo_fifo_full=1.
- burst_err clears only on reset.
- Reset mid-packet: the lock is dropped and arbitration restarts at producer 0. The partially written packet is not recovered.
- Producers must hold req_valid, req_data and req_last stable until ready; this is not checked.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - localparam-style helper function for ID width: max(1, $clog2(NUM_REQ)).
- Sub-module rr_priority_picker: combinational; inputs req vector and rr_ptr; outputs grant index and any_valid.
- The top module holds the FSM, beat counter and data mux.

Test Plan (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4):
- Single beats, all producers: req_valid=4'b1111, last=1111, data 0x10/0x20/0x30/0x40, fifo never full -> fifo_w_data sequence 0x10,0x20,0x30,0x40,0x10; grant_id 0,1,2,3,0.
- Packet lock: producer 2 sends 3 beats 0xA0,0xA1,0xA2 (last on third) while producer 0 holds valid 0x55 -> three consecutive writes A0,A1,A2 with locked=1; then 0x55 written; rr_ptr=3 after release.
- Backpressure: lock producer 1, assert fifo_full for 3 cycles mid-packet -> fifo_wr=0 and req_ready=0 for those 3 cycles; packet resumes with no lost or duplicate beat.
- Burst limit: producer 3 sends 6 beats with last=0 -> 4 beats written, then burst_err=1, state IDLE, next grant goes to producer 0 if valid.
- Wrap and sparse requests: only producer 3 valid, rr_ptr=1 -> grant 3; next grant with only producer 0 valid -> grant 0.
- Async reset mid-packet: pull reset low while LOCKED on producer 2 -> locked=0, grant_id=0 and fifo_wr=0 immediately; after release, producer 0 wins over 2 when both valid.
